// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sizes, scan FSM states and slot layout for the sprite table sink
package sprite_pkg;

  localparam int N_SPR    = 32;
  localparam int SPR_W    = 16;
  localparam int SPR_H    = 16;
  localparam int MAX_LINE = 4;
  localparam int V_LAST   = 479;

  localparam int IDX_W = 5;
  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int COL_W = 4;
  localparam int ROW_W = 4;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [X_W-1:0]   x;
    logic [ROW_W-1:0] row;
  } slot_t;

endpackage

// File: rtl/sprite_line_match.sv
// rtl/sprite_line_match.sv - decides whether one table entry covers the next line and its texel row
module sprite_line_match
  import sprite_pkg::*;
(
  input  logic             i_vis,
  input  logic [Y_W-1:0]   i_y,
  input  logic [Y_W-1:0]   i_nl,
  output logic             o_match,
  output logic [ROW_W-1:0] o_row
);

  // 10-bit unsigned difference; nl < y never matches, so there is no wrap across line 0
  logic [9:0] w_diff;

  assign w_diff  = {1'b0, i_nl} - {1'b0, i_y};
  assign o_match = i_vis && (i_nl >= i_y) && (w_diff < 10'(SPR_H));
  assign o_row   = w_diff[ROW_W-1:0];

endmodule

// File: rtl/sprite_table_sink.sv
// rtl/sprite_table_sink.sv - sprite table, per-line scan and per-pixel hit; SPRITE_SHADOW_EN adds a frame-synchronous shadow table
module sprite_table_sink
  import sprite_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [IDX_W-1:0] i_sprite_sel,
  input  logic [X_W-1:0]   i_sprite_x,
  input  logic [Y_W-1:0]   i_sprite_y,
  input  logic             i_sprite_pos,
  input  logic             i_sprite_attr,
  input  logic             i_sprite_vis,
  input  logic             i_line_start,
  input  logic             i_frame_start,
  input  logic [X_W-1:0]   i_hcount,
  input  logic [Y_W-1:0]   i_vcount,
  output logic             o_spr_hit,
  output logic [IDX_W-1:0] o_spr_idx,
  output logic [COL_W-1:0] o_spr_col,
  output logic [ROW_W-1:0] o_spr_row,
  output logic             o_spr_ovf,
  output logic             o_scan_busy
);

  logic [X_W-1:0]   r_x [N_SPR];
  logic [Y_W-1:0]   r_y [N_SPR];
  logic [N_SPR-1:0] r_vis;

`ifdef SPRITE_SHADOW_EN
  logic [X_W-1:0]   r_sh_x [N_SPR];
  logic [Y_W-1:0]   r_sh_y [N_SPR];
  logic [N_SPR-1:0] r_sh_vis;

  // a write coinciding with frame_start overrides the copy so it reaches the live table too
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < N_SPR; i++) begin
        r_x[i]    <= '0;
        r_y[i]    <= '0;
        r_sh_x[i] <= '0;
        r_sh_y[i] <= '0;
      end
      r_vis    <= '0;
      r_sh_vis <= '0;
    end else begin
      if (i_sprite_pos) begin
        r_sh_x[i_sprite_sel] <= i_sprite_x;
        r_sh_y[i_sprite_sel] <= i_sprite_y;
      end
      if (i_sprite_attr) r_sh_vis[i_sprite_sel] <= i_sprite_vis;
      if (i_frame_start) begin
        for (int i = 0; i < N_SPR; i++) begin
          r_x[i] <= r_sh_x[i];
          r_y[i] <= r_sh_y[i];
        end
        r_vis <= r_sh_vis;
        if (i_sprite_pos) begin
          r_x[i_sprite_sel] <= i_sprite_x;
          r_y[i_sprite_sel] <= i_sprite_y;
        end
        if (i_sprite_attr) r_vis[i_sprite_sel] <= i_sprite_vis;
      end
    end
  end
`else
  logic w_unused_frame_start;
  assign w_unused_frame_start = i_frame_start;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < N_SPR; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
      r_vis <= '0;
    end else begin
      if (i_sprite_pos) begin
        r_x[i_sprite_sel] <= i_sprite_x;
        r_y[i_sprite_sel] <= i_sprite_y;
      end
      if (i_sprite_attr) r_vis[i_sprite_sel] <= i_sprite_vis;
    end
  end
`endif

  scan_state_t      r_state, w_state_nxt;
  logic [IDX_W-1:0] r_scan_i;
  logic [Y_W-1:0]   r_nl, w_nl_calc;
  slot_t            r_pend [MAX_LINE];
  slot_t            r_act  [MAX_LINE];
  logic [CNT_W-1:0] r_pend_n, r_act_n;
  logic             r_pend_ovf, r_act_ovf;
  logic             w_scan_en, w_match;
  logic [ROW_W-1:0] w_row;

  assign w_nl_calc = (i_vcount == Y_W'(V_LAST)) ? '0 : i_vcount + 1'b1;
  assign w_scan_en = (r_state == ST_SCAN) && !i_line_start;

  sprite_line_match u_match (
    .i_vis   (r_vis[r_scan_i]),
    .i_y     (r_y[r_scan_i]),
    .i_nl    (r_nl),
    .o_match (w_match),
    .o_row   (w_row)
  );

  // line_start restarts the scan from any state, aborting one in progress
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: w_state_nxt = ST_IDLE;
      ST_SCAN: if (r_scan_i == IDX_W'(N_SPR - 1)) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (i_line_start) w_state_nxt = ST_SCAN;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= ST_IDLE;
      r_scan_i   <= '0;
      r_nl       <= '0;
      r_pend_n   <= '0;
      r_act_n    <= '0;
      r_pend_ovf <= 1'b0;
      r_act_ovf  <= 1'b0;
      for (int k = 0; k < MAX_LINE; k++) begin
        r_pend[k] <= '0;
        r_act[k]  <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (i_line_start) begin
        r_nl       <= w_nl_calc;
        r_scan_i   <= '0;
        r_act      <= r_pend;
        r_act_n    <= r_pend_n;
        r_act_ovf  <= r_pend_ovf;
        r_pend_n   <= '0;
        r_pend_ovf <= 1'b0;
      end else if (w_scan_en) begin
        r_scan_i <= r_scan_i + 1'b1;
        if (w_match) begin
          if (r_pend_n < CNT_W'(MAX_LINE)) begin
            r_pend[r_pend_n[1:0]] <= slot_t'{idx: r_scan_i, x: r_x[r_scan_i], row: w_row};
            r_pend_n <= r_pend_n + 1'b1;
          end else begin
            r_pend_ovf <= 1'b1;
          end
        end
      end
    end
  end

  logic [X_W-1:0]      w_dx [MAX_LINE];
  logic [MAX_LINE-1:0] w_slot_hit;
  logic [1:0]          w_win;

  for (genvar k = 0; k < MAX_LINE; k++) begin : g_slot
    assign w_dx[k]       = i_hcount - r_act[k].x;
    assign w_slot_hit[k] = (CNT_W'(k) < r_act_n) && (i_hcount >= r_act[k].x)
                           && (w_dx[k] < X_W'(SPR_W));
  end

  // walk from the top so the lowest hitting slot is the one left in w_win
  always_comb begin
    w_win = '0;
    for (int k = MAX_LINE - 1; k >= 0; k--) begin
      if (w_slot_hit[k]) w_win = 2'(k);
    end
  end

  logic             r_hit;
  logic [IDX_W-1:0] r_idx;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_hit <= 1'b0;
      r_idx <= '0;
      r_col <= '0;
      r_row <= '0;
    end else begin
      r_hit <= |w_slot_hit;
      if (|w_slot_hit) begin
        r_idx <= r_act[w_win].idx;
        r_col <= w_dx[w_win][COL_W-1:0];
        r_row <= r_act[w_win].row;
      end
    end
  end

  assign o_spr_hit   = r_hit;
  assign o_spr_idx   = r_idx;
  assign o_spr_col   = r_col;
  assign o_spr_row   = r_row;
  assign o_spr_ovf   = r_act_ovf;
  assign o_scan_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sprite_table_sink.sv
// tb/tb_sprite_table_sink.sv - directed bench with a line-list model checked every cycle
module tb_sprite_table_sink;
  import sprite_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] sel = '0;
  logic [9:0] sx = '0;
  logic [8:0] sy = '0;
  logic       pos = 1'b0, attr = 1'b0, vis = 1'b0, ls = 1'b0, fs = 1'b0;
  logic [9:0] hc = '0;
  logic [8:0] vc = '0;
  logic       hit, ovf, busy;
  logic [4:0] idx;
  logic [3:0] col, row;

  always #5 clk = ~clk;

  sprite_table_sink dut (
    .i_clk(clk), .i_reset(rst_n), .i_sprite_sel(sel), .i_sprite_x(sx), .i_sprite_y(sy),
    .i_sprite_pos(pos), .i_sprite_attr(attr), .i_sprite_vis(vis), .i_line_start(ls),
    .i_frame_start(fs), .i_hcount(hc), .i_vcount(vc), .o_spr_hit(hit), .o_spr_idx(idx),
    .o_spr_col(col), .o_spr_row(row), .o_spr_ovf(ovf), .o_scan_busy(busy)
  );

  int total = 0, bad = 0;
  bit chk_en = 0;

  // model: live (and shadow) tables, pending/active line lists, expected outputs
  int l_x[N_SPR], l_y[N_SPR], s_x[N_SPR], s_y[N_SPR];
  bit l_v[N_SPR], s_v[N_SPR];
  int p_idx[MAX_LINE], p_x[MAX_LINE], p_row[MAX_LINE], p_n;
  int a_idx[MAX_LINE], a_x[MAX_LINE], a_row[MAX_LINE], a_n;
  bit p_ovf;
  int e_hit, e_idx, e_col, e_row, e_ovf, busy_left;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_SPR; i++) begin
      l_x[i] = 0; l_y[i] = 0; l_v[i] = 0; s_x[i] = 0; s_y[i] = 0; s_v[i] = 0;
    end
    p_n = 0; a_n = 0; p_ovf = 0;
    e_hit = 0; e_idx = 0; e_col = 0; e_row = 0; e_ovf = 0; busy_left = 0;
  endtask

  task automatic build(input int nl);
    p_n = 0; p_ovf = 0;
    for (int i = 0; i < N_SPR; i++) begin
      if (l_v[i] && nl >= l_y[i] && nl - l_y[i] < SPR_H) begin
        if (p_n < MAX_LINE) begin
          p_idx[p_n] = i; p_x[p_n] = l_x[i]; p_row[p_n] = nl - l_y[i]; p_n++;
        end else p_ovf = 1;
      end
    end
  endtask

  task automatic model_edge();
    int h, nl;
    bit found;
    h = int'(hc); found = 0; e_hit = 0;
    for (int k = 0; k < a_n; k++) begin
      if (!found && h >= a_x[k] && h - a_x[k] < SPR_W) begin
        found = 1; e_hit = 1; e_idx = a_idx[k]; e_col = h - a_x[k]; e_row = a_row[k];
      end
    end
    if (busy_left > 0) busy_left--;
    if (ls) begin
      a_idx = p_idx; a_x = p_x; a_row = p_row; a_n = p_n; e_ovf = p_ovf;
      nl = (int'(vc) == V_LAST) ? 0 : int'(vc) + 1;
      build(nl);
      busy_left = N_SPR + 1;
    end
`ifdef SPRITE_SHADOW_EN
    if (fs) begin
      l_x = s_x; l_y = s_y; l_v = s_v;
    end
    if (pos) begin s_x[sel] = int'(sx); s_y[sel] = int'(sy); end
    if (attr) s_v[sel] = vis;
    if (fs && pos) begin l_x[sel] = int'(sx); l_y[sel] = int'(sy); end
    if (fs && attr) l_v[sel] = vis;
`else
    if (pos) begin l_x[sel] = int'(sx); l_y[sel] = int'(sy); end
    if (attr) l_v[sel] = vis;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (chk_en) begin
      chk("hit", int'(hit), e_hit);
      chk("idx", int'(idx), e_idx);
      chk("col", int'(col), e_col);
      chk("row", int'(row), e_row);
      chk("ovf", int'(ovf), e_ovf);
      chk("busy", int'(busy), (busy_left > 0) ? 1 : 0);
    end
  endtask

  task automatic wr(input int s, input int x, input int y, input bit v);
    sel = 5'(s); sx = 10'(x); sy = 9'(y); vis = v; pos = 1; attr = 1;
    tick();
    pos = 0; attr = 0;
  endtask

  task automatic commit();
    fs = 1; tick(); fs = 0;
  endtask

  task automatic line(input int v, input int lo, input int hi);
    int n;
    vc = 9'(v); ls = 1; hc = 10'(lo);
    tick();
    ls = 0; n = 1;
    for (int h = lo + 1; h <= hi; h++) begin
      hc = 10'(h); tick(); n++;
    end
    while (n < 40) begin tick(); n++; end
  endtask

  task automatic probe(input int h);
    hc = 10'(h); tick();
  endtask

  initial begin
    model_reset();
    #1 rst_n = 0;
    #2;
    chk("rst_hit", int'(hit), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(ovf), 0);
    @(negedge clk) rst_n = 1;
    chk_en = 1;

    // no sprites: never a hit
    for (int v = 0; v < 3; v++) line(v, 0, 63);

    // single sprite
    wr(3, 100, 50, 1); commit();
    line(49, 0, 0);
    line(50, 90, 130);
    probe(100); chk("s_hit0", int'(hit), 1); chk("s_idx", int'(idx), 3); chk("s_col0", int'(col), 0);
    probe(115); chk("s_col15", int'(col), 15); chk("s_row", int'(row), 0);
    probe(116); chk("s_miss116", int'(hit), 0); chk("s_hold_col", int'(col), 15);
    line(65, 0, 0);
    line(66, 90, 130);
    probe(100); chk("s_line66", int'(hit), 0); chk("s_hold_idx", int'(idx), 3);

    // asynchronous reset in the middle of a scan
    vc = 9'd10; ls = 1; tick(); ls = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("scan_busy_mid", int'(busy), 1);
    #2 rst_n = 0;
    #1;
    chk("ar_busy", int'(busy), 0); chk("ar_hit", int'(hit), 0); chk("ar_idx", int'(idx), 0);
    chk("ar_col", int'(col), 0); chk("ar_row", int'(row), 0); chk("ar_ovf", int'(ovf), 0);
    model_reset();
    @(negedge clk) rst_n = 1;
    for (int v = 48; v < 52; v++) line(v, 90, 130);

    // overflow: six sprites on line 20
    for (int i = 0; i < 6; i++) wr(i, 40 * i, 20, 1);
    commit();
    line(19, 0, 0);
    line(20, 0, 255);
    chk("ovf_set", int'(ovf), 1);
    probe(45); chk("o_idx1", int'(idx), 1); chk("o_col5", int'(col), 5);
    probe(165); chk("o_no_idx4", int'(hit), 0);
    line(39, 0, 0);
    line(40, 0, 255);
    chk("ovf_clr", int'(ovf), 0);

    // priority: lower slot wins on overlap
    for (int i = 0; i < 6; i++) wr(i, 40 * i, 20, 0);
    wr(2, 200, 80, 1); wr(7, 200, 75, 1); commit();
    line(79, 0, 0);
    line(80, 190, 230);
    probe(207); chk("p_idx", int'(idx), 2); chk("p_col", int'(col), 7); chk("p_row", int'(row), 0);

    // vertical wrap and right edge
    wr(2, 200, 80, 0); wr(7, 200, 75, 0);
    wr(9, 1000, 470, 1); commit();
    for (int v = 468; v <= 479; v++) line(v, 990, 1023);
    probe(1015); chk("e_hit", int'(hit), 1); chk("e_col", int'(col), 15); chk("e_row", int'(row), 9);
    probe(1016); chk("e_miss1016", int'(hit), 0);
    probe(999); chk("e_miss999", int'(hit), 0);
    for (int v = 0; v <= 6; v++) line(v, 990, 1023);
    probe(1000); chk("w_nohit", int'(hit), 0);

    // mid-frame move of sprite 12 from x=100 to x=300
    wr(9, 1000, 470, 0);
    wr(12, 100, 30, 1); commit();
    line(29, 0, 0);
    line(30, 90, 130);
    wr(12, 300, 30, 1);
    line(31, 90, 320);
    line(32, 90, 320);
`ifdef SPRITE_SHADOW_EN
    probe(100); chk("sh_old_x", int'(hit), 1); chk("sh_old_row", int'(row), 2);
    probe(300); chk("sh_new_miss", int'(hit), 0);
`else
    probe(300); chk("ns_new_x", int'(hit), 1); chk("ns_row", int'(row), 2); chk("ns_col", int'(col), 0);
    probe(100); chk("ns_old_miss", int'(hit), 0);
`endif
    commit();
    line(33, 0, 0);
    line(34, 90, 320);
    probe(300); chk("mv_hit", int'(hit), 1); chk("mv_row", int'(row), 4);
    probe(100); chk("mv_old_miss", int'(hit), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
